// File: rtl/zpu_sd_block_sequencer.sv
// Sector transfer sequencer between the ZPU register interface and the HPS SD block port.
// Owns sector-buffer port B, latches the LBA, and runs the SD_RD/SD_WR handshake with an ACK timeout.
module zpu_sd_block_sequencer #(
    parameter logic [23:0] ACK_TIMEOUT = 24'hFFFFFF,
    parameter int          ADDR_W      = 9
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ZPU_DATA_WR,
    input  logic              ZPU_DATA_RD,
    input  logic              ZPU_IO_WR,
    input  logic              ZPU_LBA_SEL,
    input  logic              ZPU_BLK_RD,
    input  logic              ZPU_BLK_WR,
    input  logic [31:0]       ZPU_WDATA,
    output logic [31:0]       ZPU_RDATA,
    output logic [7:0]        ZPU_STATUS,
    output logic [ADDR_W-1:0] BUF_ADDR,
    output logic [7:0]        BUF_DIN,
    output logic              BUF_WE,
    input  logic [7:0]        BUF_Q,
    output logic [31:0]       SD_LBA,
    output logic              SD_RD,
    output logic              SD_WR,
    input  logic              SD_ACK,
    input  logic              IMG_MOUNTED,
    input  logic [31:0]       IMG_SIZE,
    input  logic [7:0]        IMG_INDEX,
    output logic              BUSY,
    output logic              ERROR
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    logic [1:0]  state;
    logic [23:0] ack_cnt;
    logic        data_wr_q, data_rd_q, blk_rd_q, blk_wr_q, mounted_q, ack_q;
    logic        io_done, mount_toggle, readonly;
    logic [2:0]  fileno;
    logic [1:0]  filetype;
    logic [31:0] filesize;

    logic data_wr_rise, data_rd_fall, blk_rd_rise, blk_wr_rise, mount_rise, ack_fall;

    assign data_wr_rise = ZPU_DATA_WR & ~data_wr_q;
    assign data_rd_fall = ~ZPU_DATA_RD & data_rd_q;
    assign blk_rd_rise  = ZPU_BLK_RD & ~blk_rd_q;
    assign blk_wr_rise  = ZPU_BLK_WR & ~blk_wr_q;
    assign mount_rise   = IMG_MOUNTED & ~mounted_q;
    assign ack_fall     = ~SD_ACK & ack_q;

    assign BUSY       = (state != S_IDLE);
    assign ZPU_RDATA  = ZPU_LBA_SEL ? filesize : {24'b0, BUF_Q};
    assign ZPU_STATUS = {readonly, filetype, fileno, mount_toggle, io_done};

    // Edge-detect copies track the inputs during reset so a level held across reset is not an edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            data_wr_q <= ZPU_DATA_WR;
            data_rd_q <= ZPU_DATA_RD;
            blk_rd_q  <= ZPU_BLK_RD;
            blk_wr_q  <= ZPU_BLK_WR;
            mounted_q <= IMG_MOUNTED;
            ack_q     <= SD_ACK;
        end else begin
            data_wr_q <= ZPU_DATA_WR;
            data_rd_q <= ZPU_DATA_RD;
            blk_rd_q  <= ZPU_BLK_RD;
            blk_wr_q  <= ZPU_BLK_WR;
            mounted_q <= IMG_MOUNTED;
            ack_q     <= SD_ACK;
        end
    end

    // Buffer port B: byte writes only while idle; address steps after a write or a consumed read.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            BUF_ADDR <= '0;
            BUF_DIN  <= 8'd0;
            BUF_WE   <= 1'b0;
            SD_LBA   <= 32'd0;
        end else begin
            BUF_WE <= 1'b0;
            if (data_wr_rise) begin
                if (ZPU_LBA_SEL) begin
                    SD_LBA <= ZPU_WDATA;
                end else if (state == S_IDLE) begin
                    BUF_DIN <= ZPU_WDATA[7:0];
                    BUF_WE  <= 1'b1;
                end
            end
            if (ZPU_IO_WR)
                BUF_ADDR <= '0;
            else if (BUF_WE || data_rd_fall)
                BUF_ADDR <= BUF_ADDR + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state        <= S_IDLE;
            ack_cnt      <= 24'd0;
            SD_RD        <= 1'b0;
            SD_WR        <= 1'b0;
            ERROR        <= 1'b0;
            io_done      <= 1'b1;
            mount_toggle <= |IMG_SIZE;
            fileno       <= 3'd0;
            filetype     <= 2'd0;
            readonly     <= 1'b0;
            filesize     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (blk_rd_rise || blk_wr_rise) begin
                        SD_RD   <= blk_rd_rise;
                        SD_WR   <= ~blk_rd_rise;
                        io_done <= 1'b0;
                        ERROR   <= 1'b0;
                        ack_cnt <= 24'd0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (SD_ACK) begin
                        SD_RD <= 1'b0;
                        SD_WR <= 1'b0;
                        state <= S_XFER;
                    end else if (ack_cnt + 24'd1 == ACK_TIMEOUT) begin
                        SD_RD   <= 1'b0;
                        SD_WR   <= 1'b0;
                        io_done <= 1'b1;
                        ERROR   <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 24'd1;
                    end
                end
                S_XFER: begin
                    if (ack_fall) begin
                        io_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (mount_rise) begin
                mount_toggle <= ~mount_toggle;
                fileno       <= 3'd0;
                filetype     <= IMG_INDEX[7:6];
                readonly     <= 1'b1;
                filesize     <= IMG_SIZE;
            end
        end
    end

endmodule

// File: tb/tb_zpu_sd_block_sequencer.sv
// Directed bench for zpu_sd_block_sequencer with a registered 512x8 buffer model on port B.
module tb_zpu_sd_block_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_wr, data_rd, io_wr, lba_sel, blk_rd, blk_wr;
    logic [31:0] wdata, rdata;
    logic [7:0]  status;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_din, buf_q;
    logic        buf_we;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, img_mounted;
    logic [31:0] img_size;
    logic [7:0]  img_index;
    logic        busy, error;

    int checks = 0;
    int errors = 0;
    int n;

    logic [7:0] mem [512];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (buf_we) mem[buf_addr] <= buf_din;
        buf_q <= mem[buf_addr];
    end

    zpu_sd_block_sequencer #(.ACK_TIMEOUT(24'd16), .ADDR_W(9)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .ZPU_DATA_WR(data_wr), .ZPU_DATA_RD(data_rd), .ZPU_IO_WR(io_wr),
        .ZPU_LBA_SEL(lba_sel), .ZPU_BLK_RD(blk_rd), .ZPU_BLK_WR(blk_wr),
        .ZPU_WDATA(wdata), .ZPU_RDATA(rdata), .ZPU_STATUS(status),
        .BUF_ADDR(buf_addr), .BUF_DIN(buf_din), .BUF_WE(buf_we), .BUF_Q(buf_q),
        .SD_LBA(sd_lba), .SD_RD(sd_rd), .SD_WR(sd_wr), .SD_ACK(sd_ack),
        .IMG_MOUNTED(img_mounted), .IMG_SIZE(img_size), .IMG_INDEX(img_index),
        .BUSY(busy), .ERROR(error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'hEE;
        rst_n = 1'b0; data_wr = 0; data_rd = 0; io_wr = 0; lba_sel = 0;
        blk_rd = 0; blk_wr = 0; wdata = 0; sd_ack = 0; img_mounted = 0;
        img_size = 32'h2000; img_index = 0;
        tick(); tick();
        // reset state: mount_toggle=1 (size nonzero), io_done=1
        chk("rst_status", {24'b0, status}, 32'h03);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_sdrd", {31'b0, sd_rd}, 32'd0);
        chk("rst_sdwr", {31'b0, sd_wr}, 32'd0);
        chk("rst_addr", {23'b0, buf_addr}, 32'd0);
        chk("rst_err", {31'b0, error}, 32'd0);
        rst_n = 1'b1;
        tick();

        // LBA write and read request with 3-cycle ACK
        lba_sel = 1; wdata = 32'h123; data_wr = 1;
        tick();
        chk("lba", sd_lba, 32'h123);
        data_wr = 0; lba_sel = 0;
        tick();
        blk_rd = 1;
        tick();
        chk("rd_req", {30'b0, sd_rd, sd_wr}, 32'b10);
        chk("rd_done0", {31'b0, status[0]}, 32'd0);
        chk("rd_busy", {31'b0, busy}, 32'd1);
        blk_rd = 0;
        tick();
        chk("rd_hold", {31'b0, sd_rd}, 32'd1);
        sd_ack = 1;
        tick();
        chk("rd_ack_clr", {31'b0, sd_rd}, 32'd0);
        tick(); tick();
        sd_ack = 0;
        chk("xfer_done0", {31'b0, status[0]}, 32'd0);
        tick();
        chk("xfer_done1", {31'b0, status[0]}, 32'd1);
        chk("xfer_idle", {31'b0, busy}, 32'd0);

        // 512 buffer writes with wrap
        io_wr = 1; tick(); io_wr = 0; tick();
        chk("iowr_addr", {23'b0, buf_addr}, 32'd0);
        for (int i = 0; i < 512; i++) begin
            wdata = i & 32'hFF; data_wr = 1;
            tick();
            chk("wr_pulse", {22'b0, buf_we, buf_addr}, {22'b0, 1'b1, 9'(i)});
            chk("wr_din", {24'b0, buf_din}, i & 32'hFF);
            data_wr = 0;
            tick();
            chk("wr_we_low", {31'b0, buf_we}, 32'd0);
        end
        chk("wrap_addr", {23'b0, buf_addr}, 32'd0);

        // readback through ZPU_RDATA
        tick();
        chk("rdata0", rdata, 32'h00);
        data_rd = 1; tick(); data_rd = 0; tick(); tick();
        chk("rd_addr1", {23'b0, buf_addr}, 32'd1);
        chk("rdata1", rdata, 32'h01);
        data_rd = 1; tick();
        data_rd = 0; io_wr = 1; tick();
        chk("iowr_override", {23'b0, buf_addr}, 32'd0);
        io_wr = 0; tick();

        // write request; byte writes while busy are dropped
        blk_wr = 1; tick();
        chk("wr_req", {30'b0, sd_rd, sd_wr}, 32'b01);
        blk_wr = 0;
        wdata = 32'hAA; data_wr = 1; tick();
        chk("busy_no_we", {31'b0, buf_we}, 32'd0);
        data_wr = 0; tick();
        chk("busy_addr", {23'b0, buf_addr}, 32'd0);
        sd_ack = 1; tick(); sd_ack = 0; tick();
        chk("wr_done", {29'b0, status[0], sd_wr, busy}, 32'b100);
        tick(); tick();
        chk("busy_mem", {24'b0, buf_q}, 32'h00);

        // simultaneous edges: read wins; BLK_WR during REQ ignored
        blk_rd = 1; blk_wr = 1; tick();
        chk("both_req", {30'b0, sd_rd, sd_wr}, 32'b10);
        blk_rd = 0; blk_wr = 0; tick();
        blk_wr = 1; tick();
        chk("req_ign_wr", {30'b0, sd_rd, sd_wr}, 32'b10);
        blk_wr = 0;
        repeat (20) tick();
        chk("to1_err", {30'b0, error, sd_rd}, 32'b10);

        // timeout length, ERROR cleared on new request
        blk_rd = 1; tick();
        chk("to_start", {30'b0, sd_rd, error}, 32'b10);
        blk_rd = 0;
        n = 0;
        while (n < 100) begin
            tick(); n++;
            if (!sd_rd) break;
        end
        chk("to_cycles", n, 32'd16);
        chk("to_flags", {29'b0, error, status[0], busy}, 32'b110);

        // mount during XFER
        blk_rd = 1; tick(); blk_rd = 0;
        sd_ack = 1; tick();
        img_index = 8'h40; img_size = 32'h8010; img_mounted = 1; tick();
        chk("mnt_status", {24'b0, status}, 32'hA0);
        lba_sel = 1; #1;
        chk("mnt_size", rdata, 32'h8010);
        lba_sel = 0;
        sd_ack = 0; tick();
        chk("mnt_done", {23'b0, status, busy}, {23'b0, 8'hA1, 1'b0});

        // reset mid-request; late ACK ignored
        blk_wr = 1; tick(); blk_wr = 0;
        rst_n = 0; tick();
        chk("rst_mid", {21'b0, status, sd_wr, sd_rd, busy}, {21'b0, 8'h03, 3'b000});
        rst_n = 1; sd_ack = 1; tick(); tick();
        sd_ack = 0; tick();
        chk("late_ack", {30'b0, busy, status[0]}, 32'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
